io_stream_fifo: RTL and testbench
=================================

Name: io_stream_fifo

Overview:
- Clocked, parametrised successor to the shift-queue I/O devices of the bfX core.
- Buffers a byte stream between a producer and a consumer using valid/ready handshakes on both sides, in a circular buffer of configurable width and depth.
- Returns a configurable EOF value when the consumer reads an empty buffer, matching Brainfuck `,` semantics.
- Has sticky overflow/underflow flags and a synchronous flush.
- Instantiated twice: core input stream (fed by the testbench/host) and core output stream (drained by the testbench/host).

Parameters:
- DATA_W, 8, width of each stream word.
- DEPTH, 16, number of storage entries; any integer >= 2; not required to be a power of two.
- EOF_VAL, 0, value driven on rd_data while the buffer is empty.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of contents and flags.
- wr_valid  in  1  producer offers wr_data.
- wr_ready  out  1  buffer can accept a word (not full).
- wr_data  in  DATA_W  word to store.
- rd_valid  out  1  rd_data holds a real stored word (not empty).
- rd_ready  in  1  consumer takes rd_data this cycle.
- rd_data  out  DATA_W  head word, or EOF_VAL when empty.
- count  out  $clog2(DEPTH+1)  number of stored words.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (rst high, asynchronous):
  - wr_ptr = rd_ptr = count = 0.
  - Outputs: full = 0, empty = 1, wr_ready = 1, rd_valid = 0, rd_data = EOF_VAL, overflow = underflow = 0.
  - Storage array is not reset.
  - Reset mid-transfer discards all contents with no partial state.
- Push:
  - Fires when wr_valid && wr_ready.
  - mem[wr_ptr] <= wr_data; wr_ptr advances by 1 and wraps from DEPTH-1 to 0.
- Pop:
  - Fires when rd_valid && rd_ready.
  - rd_ptr advances by 1 with the same wrap.
- Handshake is first-word fall-through:
  - rd_data = mem[rd_ptr] combinationally when not empty, else EOF_VAL.
  - A word pushed at edge N is visible on rd_data with rd_valid = 1 after edge N (one-cycle write-to-read latency).
- Flags derive from count:
  - wr_ready = !full; rd_valid = !empty.
  - All flags derive from registered count; there is no combinational path from rd_ready to wr_ready or from wr_valid to rd_valid.
- Count:
  - Push only: +1. Pop only: -1. Both or neither: unchanged.
- Simultaneous events:
  - Full, with wr_valid and rd_ready both high: pop occurs, push is rejected, overflow sets; count becomes DEPTH-1.
  - Empty, with wr_valid and rd_ready both high: push occurs, pop does not, underflow sets, rd_data shows EOF_VAL that cycle; count becomes 1.
  - Partially filled, push and pop together: both occur, count unchanged, pointers both advance.
- Sticky flags:
  - overflow sets on any cycle with wr_valid && full.
  - underflow sets on any cycle with rd_ready && empty.
  - Both stay set until rst or flush.
- Flush (synchronous, rst has priority):
  - Pointers, count and both sticky flags return to reset values on the next edge.
  - Any push/pop in the flush cycle is ignored.
- Wrap-around:
  - Pointer compare uses explicit equality with DEPTH-1, never modulo by bit truncation, so non-power-of-two DEPTH works.
  - After more than DEPTH total pushes, read order remains FIFO.

Decomposition:
- Shared package bf_io_pkg:
  - BF_DATA_W = 8.
  - BF_EOF_VAL = 0.
  - Default depth constant BF_IO_DEPTH = 16.
- One sub-module, io_wrap_ptr:
  - Parameters DEPTH and width.
  - Inputs clk, rst, clr, inc; output ptr.
  - Wraps DEPTH-1 to 0 with the same async reset and synchronous clear.
  - Instantiated twice (write and read pointers).
- count/full/empty and the sticky flags remain in io_stream_fifo.

Test Plan:
- Reset with DEPTH=4 -> wr_ready=1, rd_valid=0, empty=1, count=0, rd_data=0x00. Push 0x11,0x22,0x33 on consecutive cycles -> count=3. Pop 3 with rd_ready held -> rd_data 0x11,0x22,0x33 in order, then empty=1, rd_data=0x00.
- DEPTH=4: push 0xA0..0xA3 -> full=1, wr_ready=0. Push 0xFF with no pop -> rejected, overflow=1, count=4. Pop all -> 0xA0..0xA3 returned, 0xFF never appears, overflow still 1.
- Empty buffer: rd_ready=1 for one cycle -> underflow=1, count stays 0, rd_data=EOF_VAL. Repeat with EOF_VAL=0xFF -> rd_data=0xFF.
- DEPTH=5 (non-power-of-two): 12 pushes interleaved with pops, keeping count between 1 and 5 -> output sequence equals input sequence and pointers wrap twice. Full with wr_valid and rd_ready both high -> count becomes 4, overflow=1.
- Empty with wr_valid=1 (0x5A) and rd_ready=1 in the same cycle -> count=1, underflow=1, next cycle rd_valid=1, rd_data=0x5A.
- Fill 3 words, set flags, pulse flush together with wr_valid -> next edge count=0, empty=1, overflow=underflow=0, flush-cycle word not stored. Assert rst asynchronously between clock edges mid-stream -> outputs hit reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/bf_io_pkg.sv
// Shared constants for the bfX core I/O stream buffers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   BF_DATA_W   - default stream word width (one Brainfuck cell)
//   BF_EOF_VAL  - default value returned when a consumer reads an empty stream
//   BF_IO_DEPTH - default number of buffered words per stream
//   ptr_w()     - pointer width helper that stays >= 1 for tiny depths
package bf_io_pkg;

    localparam int BF_DATA_W   = 8;
    localparam int BF_IO_DEPTH = 16;

    localparam logic [BF_DATA_W-1:0] BF_EOF_VAL = '0;

    // Width of a pointer addressing DEPTH entries. $clog2(1) is 0, which would
    // produce a zero-width vector, so clamp to one bit.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/io_wrap_ptr.sv
// Circular buffer pointer that counts 0..DEPTH-1 and wraps back to 0.
// Latency: pointer moves on the rising edge after inc is sampled high.
// Backpressure: none; the owner decides when inc may be asserted.
//
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-high reset, forces ptr to 0
//   clr - synchronous clear to 0, takes priority over inc
//   inc - advance the pointer by one entry
//   ptr - current entry index
module io_wrap_ptr #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    // The wrap point is an explicit compare against the last index rather than
    // relying on natural overflow, so depths that are not a power of two work.
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            if (ptr == LAST_IDX) begin
                ptr <= '0;
            end else begin
                ptr <= ptr + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/io_stream_fifo.sv
// Byte-stream FIFO between a producer and a consumer, with EOF value on empty reads.
// Latency: first-word fall-through; a word pushed at edge N is on rd_data after edge N.
// Backpressure: wr_ready drops when full, rd_valid drops when empty; both from registered count.
//
// Ports:
//   clk, rst              - rising-edge clock, asynchronous active-high reset
//   flush                 - synchronous clear of contents and sticky flags
//   wr_valid/wr_ready     - producer handshake, wr_data stored when both high
//   wr_data               - word offered by the producer
//   rd_valid/rd_ready     - consumer handshake, head word removed when both high
//   rd_data               - head word, or EOF_VAL while the buffer is empty
//   count                 - number of stored words
//   full, empty           - count == DEPTH, count == 0
//   overflow, underflow   - sticky: write seen while full, read seen while empty
module io_stream_fifo
    import bf_io_pkg::*;
#(
    parameter int                 DATA_W  = BF_DATA_W,
    parameter int                 DEPTH   = BF_IO_DEPTH,
    parameter logic [DATA_W-1:0]  EOF_VAL = BF_EOF_VAL
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,

    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [DATA_W-1:0]          wr_data,

    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [DATA_W-1:0]          rd_data,

    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Storage is deliberately left without reset: validity is tracked purely
    // by count, so stale entries are never observable.
    logic [DATA_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push;
    logic              pop;

    // ------------------------------------------------------------------
    // Status, all derived from the registered count. Keeping them off the
    // handshake inputs means there is no combinational path from rd_ready
    // to wr_ready or from wr_valid to rd_valid.
    // ------------------------------------------------------------------
    assign full     = (count == CNT_FULL);
    assign empty    = (count == '0);
    assign wr_ready = !full;
    assign rd_valid = !empty;

    // A flush cycle swallows any handshake so nothing is half-applied.
    assign push = wr_valid && wr_ready && !flush;
    assign pop  = rd_valid && rd_ready && !flush;

    // Fall-through head; EOF_VAL stands in for data when nothing is stored,
    // which is what the core's input instruction expects on end of stream.
    assign rd_data = empty ? EOF_VAL : mem[rd_ptr];

    // ------------------------------------------------------------------
    // Pointers
    // ------------------------------------------------------------------
    io_wrap_ptr #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (push),
        .ptr (wr_ptr)
    );

    io_wrap_ptr #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (pop),
        .ptr (rd_ptr)
    );

    // ------------------------------------------------------------------
    // Storage write
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Occupancy. Push and pop in the same cycle cancel; when full, push is
    // already masked by wr_ready, and when empty, pop is masked by rd_valid,
    // so the simultaneous corner cases fall out of the same case statement.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sticky error flags. They look at the raw request, not the accepted
    // handshake: any attempt to write while full or read while empty counts.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_valid && full) begin
                overflow <= 1'b1;
            end
            if (rd_ready && empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_io_stream_fifo.sv
// Bench for io_stream_fifo: three instances (depth 4, depth 5, depth 3 with EOF 0xFF)
// share one stimulus stream; each is compared every cycle against a queue model.
// Directed steps first, then a randomized phase.
module tb_io_stream_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       rd_ready;

    always #5 clk = ~clk;

    // Observed outputs, one slot per instance.
    logic [7:0] o_data [3];
    logic [3:0] o_cnt  [3];
    logic       o_full [3];
    logic       o_empty[3];
    logic       o_wrdy [3];
    logic       o_rvld [3];
    logic       o_ovf  [3];
    logic       o_unf  [3];

    logic [2:0] c4;
    logic [2:0] c5;
    logic [1:0] c3;

    assign o_cnt[0] = {1'b0, c4};
    assign o_cnt[1] = {1'b0, c5};
    assign o_cnt[2] = {2'b00, c3};

    io_stream_fifo #(.DATA_W(8), .DEPTH(4), .EOF_VAL(8'h00)) u_d4 (
        .clk(clk), .rst(rst), .flush(flush),
        .wr_valid(wr_valid), .wr_ready(o_wrdy[0]), .wr_data(wr_data),
        .rd_valid(o_rvld[0]), .rd_ready(rd_ready), .rd_data(o_data[0]),
        .count(c4), .full(o_full[0]), .empty(o_empty[0]),
        .overflow(o_ovf[0]), .underflow(o_unf[0])
    );

    io_stream_fifo #(.DATA_W(8), .DEPTH(5), .EOF_VAL(8'h00)) u_d5 (
        .clk(clk), .rst(rst), .flush(flush),
        .wr_valid(wr_valid), .wr_ready(o_wrdy[1]), .wr_data(wr_data),
        .rd_valid(o_rvld[1]), .rd_ready(rd_ready), .rd_data(o_data[1]),
        .count(c5), .full(o_full[1]), .empty(o_empty[1]),
        .overflow(o_ovf[1]), .underflow(o_unf[1])
    );

    io_stream_fifo #(.DATA_W(8), .DEPTH(3), .EOF_VAL(8'hFF)) u_d3 (
        .clk(clk), .rst(rst), .flush(flush),
        .wr_valid(wr_valid), .wr_ready(o_wrdy[2]), .wr_data(wr_data),
        .rd_valid(o_rvld[2]), .rd_ready(rd_ready), .rd_data(o_data[2]),
        .count(c3), .full(o_full[2]), .empty(o_empty[2]),
        .overflow(o_ovf[2]), .underflow(o_unf[2])
    );

    // ------------------------------------------------------------------
    // Reference model: a queue of stored words per instance plus flags.
    // ------------------------------------------------------------------
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] q2[$];
    int         dep [3] = '{4, 5, 3};
    logic [7:0] eofv[3] = '{8'h00, 8'h00, 8'hFF};
    bit         m_ovf[3];
    bit         m_unf[3];

    int total = 0;
    int bad   = 0;

    function automatic int qsize(input int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [7:0] qhead(input int i);
        case (i)
            0:       return q0[0];
            1:       return q1[0];
            default: return q2[0];
        endcase
    endfunction

    task automatic model_reset();
        q0.delete();
        q1.delete();
        q2.delete();
        for (int i = 0; i < 3; i++) begin
            m_ovf[i] = 1'b0;
            m_unf[i] = 1'b0;
        end
    endtask

    // One clock edge of FIFO behaviour, straight from the handshake rules.
    task automatic model_step(input int i, input bit wv, input logic [7:0] wd,
                              input bit rr, input bit fl);
        int n;
        bit do_pop;
        bit do_push;
        n = qsize(i);
        if (fl) begin
            case (i)
                0:       q0.delete();
                1:       q1.delete();
                default: q2.delete();
            endcase
            m_ovf[i] = 1'b0;
            m_unf[i] = 1'b0;
        end else begin
            do_pop  = rr && (n > 0);
            do_push = wv && (n < dep[i]);
            if (wv && n == dep[i]) m_ovf[i] = 1'b1;
            if (rr && n == 0)      m_unf[i] = 1'b1;
            case (i)
                0: begin
                    if (do_pop)  q0.delete(0);
                    if (do_push) q0.push_back(wd);
                end
                1: begin
                    if (do_pop)  q1.delete(0);
                    if (do_push) q1.push_back(wd);
                end
                default: begin
                    if (do_pop)  q2.delete(0);
                    if (do_push) q2.push_back(wd);
                end
            endcase
        end
    endtask

    task automatic chk(input string tag, input int inst,
                       input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s u%0d observed=0x%0h expected=0x%0h", tag, inst, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 3; i++) begin
            int n;
            logic [7:0] exp_d;
            n     = qsize(i);
            exp_d = (n == 0) ? eofv[i] : qhead(i);
            chk({tag, ".count"},     i, 32'(o_cnt[i]),   32'(n));
            chk({tag, ".full"},      i, 32'(o_full[i]),  32'(n == dep[i]));
            chk({tag, ".empty"},     i, 32'(o_empty[i]), 32'(n == 0));
            chk({tag, ".wr_ready"},  i, 32'(o_wrdy[i]),  32'(n != dep[i]));
            chk({tag, ".rd_valid"},  i, 32'(o_rvld[i]),  32'(n != 0));
            chk({tag, ".rd_data"},   i, 32'(o_data[i]),  32'(exp_d));
            chk({tag, ".overflow"},  i, 32'(o_ovf[i]),   32'(m_ovf[i]));
            chk({tag, ".underflow"}, i, 32'(o_unf[i]),   32'(m_unf[i]));
        end
    endtask

    // Drive one cycle's inputs, check current state (including rd_data during
    // the handshake cycle), then advance the model with the DUT across the edge.
    task automatic cycle(input string tag, input bit wv, input logic [7:0] wd,
                         input bit rr, input bit fl);
        wr_valid = wv;
        wr_data  = wd;
        rd_ready = rr;
        flush    = fl;
        #1;
        check_all(tag);
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_step(i, wv, wd, rr, fl);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        flush    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        rd_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        rst = 1'b0;

        // Basic push three, pop three in order, then EOF on empty.
        cycle("push", 1'b1, 8'h11, 1'b0, 1'b0);
        cycle("push", 1'b1, 8'h22, 1'b0, 1'b0);
        cycle("push", 1'b1, 8'h33, 1'b0, 1'b0);
        cycle("pop",  1'b0, 8'h00, 1'b1, 1'b0);
        cycle("pop",  1'b0, 8'h00, 1'b1, 1'b0);
        cycle("pop",  1'b0, 8'h00, 1'b1, 1'b0);
        cycle("idle", 1'b0, 8'h00, 1'b0, 1'b0);

        // Fill to full, overfill with 0xFF, then drain past empty.
        for (int k = 0; k < 4; k++) cycle("fill", 1'b1, 8'hA0 + 8'(k), 1'b0, 1'b0);
        cycle("ovf", 1'b1, 8'hFF, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) cycle("drain", 1'b0, 8'h00, 1'b1, 1'b0);
        cycle("idle", 1'b0, 8'h00, 1'b0, 1'b0);

        // Clear flags, then stream 12 words through with overlap so the
        // depth-5 pointers wrap twice.
        cycle("flush", 1'b0, 8'h00, 1'b0, 1'b1);
        for (int k = 0; k < 12; k++) cycle("stream", 1'b1, 8'h30 + 8'(k), (k >= 2), 1'b0);
        cycle("top", 1'b1, 8'h60, 1'b0, 1'b0);
        cycle("top", 1'b1, 8'h61, 1'b0, 1'b0);
        cycle("top", 1'b1, 8'h62, 1'b0, 1'b0);
        cycle("fullboth", 1'b1, 8'h77, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) cycle("drain2", 1'b0, 8'h00, 1'b1, 1'b0);

        // Empty with push and pop together.
        cycle("flush", 1'b0, 8'h00, 1'b0, 1'b1);
        cycle("emptyboth", 1'b1, 8'h5A, 1'b1, 1'b0);
        cycle("after", 1'b0, 8'h00, 1'b0, 1'b0);

        // Set both flags, refill, then flush together with a write.
        cycle("pop", 1'b0, 8'h00, 1'b1, 1'b0);
        cycle("pop", 1'b0, 8'h00, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) cycle("refill", 1'b1, 8'hC0 + 8'(k), 1'b0, 1'b0);
        cycle("ovf2", 1'b1, 8'hC9, 1'b0, 1'b0);
        cycle("flushwr", 1'b1, 8'hEE, 1'b0, 1'b1);
        cycle("postflush", 1'b0, 8'h00, 1'b0, 1'b0);

        // Asynchronous reset between edges while holding data and flags.
        cycle("pre_rst", 1'b1, 8'h91, 1'b0, 1'b0);
        cycle("pre_rst", 1'b1, 8'h92, 1'b1, 1'b0);
        cycle("pre_rst", 1'b0, 8'h00, 1'b1, 1'b0);
        cycle("pre_rst", 1'b0, 8'h00, 1'b1, 1'b0);
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst = 1'b0;
        check_all("rst_release");

        // Randomized traffic with occasional flushes.
        for (int k = 0; k < 400; k++) begin
            cycle("rand",
                  1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 31) == 0));
        end
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        flush    = 1'b0;
        #1;
        check_all("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
